block_serializer: RTL
=====================

Name: block_serializer

Overview:
- Transmit-side counterpart of the 16-word block preprocessor: accepts one 512-bit block and emits it as 16 sequential 32-bit words.
- Word 0 (bits [31:0]) is sent first and word 15 (bits [511:480]) last. This is the order in which the preprocessor packs arriving words, so a serializer feeding a preprocessor reproduces the original block.
- Sits between block-level producers (hash/crypto cores) and the 32-bit packet bus.

Parameters:
- WORD_W, 32, width of one output word.
- NUM_WORDS, 16, words per block.
- Derived localparams, not overridable: BLOCK_W = WORD_W*NUM_WORDS; IDX_W = $clog2(NUM_WORDS).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- data_in  input  BLOCK_W  block to transmit.
- data_valid  input  1  data_in holds a valid block.
- in_ready  output  1  serializer can accept a block.
- pkg_out  output  WORD_W  current output word.
- pkg_valid  output  1  pkg_out is valid.
- pkg_ready  input  1  downstream accepts pkg_out this cycle.
- block_done  output  1  one-cycle pulse after the last word of a block transfers.

Behaviour:
- Reset is sampled only at posedge clk with rst=1. It produces:
  - state=IDLE, shift register=0, idx=0;
  - pkg_valid=0, pkg_out=0, block_done=0.
  - in_ready is 0 while rst=1.
- Reset mid-block discards the remaining words. No block_done is issued for the discarded block.
- States:
  - IDLE: in_ready = !rst. No output.
  - SEND: in_ready=0, pkg_valid=1.
- Load:
  - A block loads when data_valid && in_ready at a posedge. data_in is captured into a BLOCK_W shift register, idx=0, and the state moves to SEND.
  - Load latency is 1 cycle: pkg_valid rises and pkg_out = data_in[WORD_W-1:0] in the cycle after the load edge.
- Output path:
  - pkg_out is always shreg[WORD_W-1:0].
  - pkg_out and pkg_valid are stable while pkg_valid && !pkg_ready. Stall length is unbounded.
- Transfer:
  - A transfer occurs when pkg_valid && pkg_ready at a posedge.
  - On transfer, shreg shifts right by WORD_W with zero-fill from the top, and idx increments.
- Last word (transfer with idx == NUM_WORDS-1):
  - next state IDLE, pkg_valid=0, block_done=1 for exactly one cycle.
  - shreg is 0 after the shift, so pkg_out reads 0 in IDLE.
  - idx wraps to 0; no overflow is possible.
- Throughput:
  - Minimum is NUM_WORDS+1 cycles per block: 1 load cycle plus 16 transfers.
  - Back-to-back blocks are allowed. in_ready is 1 in the cycle block_done is high, so the next load may occur on that edge.
- data_valid while in SEND: ignored. The producer must hold data_valid and data_in until in_ready.
- pkg_ready while pkg_valid=0: no effect.
- If rst and a load are both present at the same edge, rst wins.
- Every register updates only on posedge clk. There are no negedge or asynchronous processes.

Optional Feature:
- Macro: BLOCK_SERIALIZER_WORD_IDX_EN.
- Defined:
  - Adds output port word_idx [IDX_W-1:0], equal to idx. It gives the index of the word currently on pkg_out.
  - Adds output port last_word, asserted combinationally when pkg_valid && idx == NUM_WORDS-1.
  - Reset value of both is 0.
- Undefined: neither port exists. Core behaviour is identical.

Test Plan:
- Basic block:
  - Stimulus: rst 2 cycles, then data_valid=1 with word i = 0x4E4+2*i (word0=0x4E4, word15=0x502), pkg_ready held 1.
  - Response: pkg_valid for exactly 16 consecutive cycles; pkg_out = 0x4E4, 0x4E6, … 0x502; block_done high the cycle after 0x502; pkg_out=0 afterwards.
- Backpressure:
  - Stimulus: same block, pkg_ready=0 for 3 cycles on words 0, 7 and 15.
  - Response: each of those words is held stable during its stall; no word is duplicated or skipped; total of 16 transfers.
- Busy load ignored:
  - Stimulus: a second data_valid with a different block (all words 0xFFFFFFFF) while in SEND.
  - Response: in_ready=0; the first block's words are unaffected; the second block starts only after block_done.
- Back-to-back blocks:
  - Stimulus: two blocks presented continuously, pkg_ready=1.
  - Response: 32 words in order; exactly one cycle without pkg_valid between them; two block_done pulses.
- Reset mid-block:
  - Stimulus: rst=1 for 1 cycle after word 5 transfers.
  - Response: next cycle pkg_valid=0, pkg_out=0, block_done=0; a new block then starts again at word 0.
- Optional feature (BLOCK_SERIALIZER_WORD_IDX_EN defined):
  - Stimulus: basic block.
  - Response: word_idx steps 0..15 with pkg_out; last_word high only with 0x502.

Source files
------------

// File: rtl/block_serializer.sv
// Serializes one 512-bit block into 16 x 32-bit words, word 0 first.
// Optional word_idx/last_word outputs are enabled by BLOCK_SERIALIZER_WORD_IDX_EN.
module block_serializer #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned NUM_WORDS = 16,
  localparam int unsigned BLOCK_W  = WORD_W * NUM_WORDS,
  localparam int unsigned IDX_W    = $clog2(NUM_WORDS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BLOCK_W-1:0] data_in,
  input  logic               data_valid,
  output logic               in_ready,
  output logic [WORD_W-1:0]  pkg_out,
  output logic               pkg_valid,
  input  logic               pkg_ready,
`ifdef BLOCK_SERIALIZER_WORD_IDX_EN
  output logic [IDX_W-1:0]   word_idx,
  output logic               last_word,
`endif
  output logic               block_done
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e              state_q;
  logic [BLOCK_W-1:0]  shreg_q;
  logic [IDX_W-1:0]    idx_q;
  logic                done_q;
  logic                is_last;

  assign is_last = (idx_q == IDX_W'(NUM_WORDS - 1));

  // Load, shift-out and last-word handling; reset discards any partial block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (data_valid) begin
            shreg_q <= data_in;
            idx_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (pkg_ready) begin
            shreg_q <= shreg_q >> WORD_W;
            idx_q   <= idx_q + IDX_W'(1);
            if (is_last) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // in_ready must drop in the reset cycle itself, hence the direct rst term.
  assign in_ready   = (state_q == IDLE) && !rst;
  assign pkg_valid  = (state_q == SEND);
  assign pkg_out    = shreg_q[WORD_W-1:0];
  assign block_done = done_q;

`ifdef BLOCK_SERIALIZER_WORD_IDX_EN
  assign word_idx  = idx_q;
  assign last_word = pkg_valid && is_last;
`endif

endmodule
